// File: rtl/alu_issue_arb_pkg.sv
// Shared types and constants for the two-requester ALU issue arbiter.
package alu_issue_arb_pkg;

    // Operation fields presented to the shared ALU (request payload minus tag)
    localparam int ALU_OP_W  = 184;
    // Tag width used by the reference request layout below
    localparam int DEF_TAG_W = 4;

    localparam logic [5:0] OP_XO_X  = 6'd31;
    localparam logic [5:0] OP_B     = 6'd19;
    localparam logic [5:0] OP_I     = 6'd18;
    localparam logic [5:0] OP_D     = 6'd14;
    localparam logic [5:0] OP_DS_LD = 6'd58;
    localparam logic [5:0] OP_DS_ST = 6'd62;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [9:0]  xox;
        logic [8:0]  xoxo;
        logic        aa;
        logic [15:0] si;
        logic [13:0] ds;
        logic [63:0] rs_val;
        logic [63:0] rt_val;
    } alu_op_t;

    // Full request payload: operation fields on top, tag in the low bits.
    // The top module slices its TAG_W-wide ports with the same layout.
    typedef struct packed {
        alu_op_t              op;
        logic [DEF_TAG_W-1:0] tag;
    } alu_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } arb_state_e;

    typedef struct packed {
        logic [63:0] result;
        logic        branch;
        logic        err;
    } alu_rsp_t;

    // Opcodes outside the supported set, or an XO-form with no extended opcode
    function automatic logic op_illegal(input alu_op_t op);
        logic known;
        known = (op.opcode == OP_XO_X)  || (op.opcode == OP_B)     ||
                (op.opcode == OP_I)     || (op.opcode == OP_D)     ||
                (op.opcode == OP_DS_LD) || (op.opcode == OP_DS_ST);
        return !known || (op.opcode == OP_XO_X && op.xox == '0 && op.xoxo == '0);
    endfunction

    // Shape the raw ALU outcome into the response fields
    function automatic alu_rsp_t form_rsp(input alu_op_t op, input logic [63:0] res,
                                          input logic br);
        alu_rsp_t r;
        r = '0;
        if (op_illegal(op)) begin
            r.err = 1'b1;
        end else begin
            r.result = res;
            if (op.opcode == OP_I)
                r.branch = 1'b1;          // unconditional branch
            else if (op.opcode == OP_B)
                r.branch = br;            // conditional: trust the ALU
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_arb_rr_arb2.sv
// Two-way round-robin grant. Pointer state lives in the caller; this block
// produces the one-hot grant and the pointer value to load on an update.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       update_i,
    input  logic       ptr_i,     // requester currently holding priority
    output logic [1:0] grant_o,
    output logic       ptr_d_o
);

    // Contention goes to the pointer; a lone requester always wins
    assign grant_o = (valid_i == 2'b11) ? (ptr_i ? 2'b10 : 2'b01) : valid_i;

    // After a grant, priority passes to the other requester
    assign ptr_d_o = (update_i && (|grant_o)) ? ~grant_o[1] : ptr_i;

endmodule

// File: rtl/alu_issue_arb.sv
// Shares one external ALU between two requesters: round-robin accept, hold the
// operation for EXEC_CYCLES settle cycles, then present a response until taken.
module alu_issue_arb
    import alu_issue_arb_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int TAG_W       = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [ALU_OP_W+TAG_W-1:0] req0_pld,
    input  logic [ALU_OP_W+TAG_W-1:0] req1_pld,
    output logic [ALU_OP_W-1:0]       alu_pld,
    input  logic [63:0]               alu_result,
    input  logic                      alu_branch,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_id,
    output logic [TAG_W-1:0]          rsp_tag,
    output logic [63:0]               rsp_result,
    output logic                      rsp_branch,
    output logic                      rsp_err
);

    localparam int         PLD_W    = ALU_OP_W + TAG_W;
    localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

    arb_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  ptr_q, ptr_d;
    logic [1:0]            grant;
    logic                  grant_upd;
    logic                  exec_done;
    logic [1:0][PLD_W-1:0] req_pld;
    logic [PLD_W-1:0]      sel_pld;
    alu_op_t               op_q;
    logic [TAG_W-1:0]      tag_q;
    logic                  id_q;
    alu_rsp_t              rsp_q, rsp_d;

    assign req_pld = {req1_pld, req0_pld};
    assign sel_pld = req_pld[grant[1]];

    rr_arb2 u_rr (
        .valid_i  (req_valid),
        .update_i (grant_upd),
        .ptr_i    (ptr_q),
        .grant_o  (grant),
        .ptr_d_o  (ptr_d)
    );

    assign exec_done = (state_q == ST_EXEC) && (cnt_q == LAST_CNT);

    // Next state, settle counter and the combinational accept
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_upd = 1'b0;
        req_ready = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (rst_n && (|grant)) begin
                    req_ready = grant;
                    grant_upd = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                // No bypass: a new request is only considered back in IDLE
                if (rsp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, counter and priority pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Latch the granted operation; it drives the ALU until the next grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            tag_q <= '0;
            id_q  <= 1'b0;
        end else if (grant_upd) begin
            op_q  <= alu_op_t'(sel_pld[PLD_W-1 -: ALU_OP_W]);
            tag_q <= sel_pld[TAG_W-1:0];
            id_q  <= grant[1];
        end
    end

    assign rsp_d = form_rsp(op_q, alu_result, alu_branch);

    // Capture the ALU outcome on the final settle cycle only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_q <= '0;
        else if (exec_done)
            rsp_q <= rsp_d;
    end

    assign alu_pld    = op_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = id_q;
    assign rsp_tag    = tag_q;
    assign rsp_result = rsp_q.result;
    assign rsp_branch = rsp_q.branch;
    assign rsp_err    = rsp_q.err;

endmodule

// File: tb/tb_alu_issue_arb.sv
// Scoreboard bench for alu_issue_arb: one-cycle instance plus a 3-cycle instance.
module tb_alu_issue_arb;
    import alu_issue_arb_pkg::*;

    localparam int TW = 4;
    localparam int PW = ALU_OP_W + TW;
    localparam int E1 = 1;

    typedef struct {
        logic          id;
        logic [TW-1:0] tag;
        logic [63:0]   result;
        logic          branch;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]          req_valid, req_ready;
    logic [PW-1:0]       req0_pld, req1_pld;
    logic [ALU_OP_W-1:0] alu_pld;
    logic [63:0]         alu_result;
    logic                alu_branch;
    logic                rsp_valid, rsp_ready, rsp_id;
    logic [TW-1:0]       rsp_tag;
    logic [63:0]         rsp_result;
    logic                rsp_branch, rsp_err;

    logic [1:0]          req_valid_3, req_ready_3;
    logic [PW-1:0]       req0_pld_3, req1_pld_3;
    logic [ALU_OP_W-1:0] alu_pld_3;
    logic [63:0]         alu_result_3;
    logic                alu_branch_3;
    logic                rsp_valid_3, rsp_ready_3, rsp_id_3;
    logic [TW-1:0]       rsp_tag_3;
    logic [63:0]         rsp_result_3;
    logic                rsp_branch_3, rsp_err_3;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sbq[$];
    logic mptr;
    logic tb_br;

    function automatic logic [63:0] alu_model(input alu_op_t o);
        logic [63:0] r;
        case (o.opcode)
            6'd14:   r = o.rt_val + {{48{o.si[15]}}, o.si};
            6'd31:   r = o.rs_val + o.rt_val;
            default: r = o.rs_val ^ o.rt_val;
        endcase
        return r;
    endfunction

    assign alu_result = alu_model(alu_op_t'(alu_pld));
    assign alu_branch = tb_br;

    alu_issue_arb #(.EXEC_CYCLES(E1), .TAG_W(TW)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req0_pld(req0_pld), .req1_pld(req1_pld), .alu_pld(alu_pld),
        .alu_result(alu_result), .alu_branch(alu_branch),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_branch(rsp_branch),
        .rsp_err(rsp_err)
    );

    alu_issue_arb #(.EXEC_CYCLES(3), .TAG_W(TW)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_3), .req_ready(req_ready_3),
        .req0_pld(req0_pld_3), .req1_pld(req1_pld_3), .alu_pld(alu_pld_3),
        .alu_result(alu_result_3), .alu_branch(alu_branch_3),
        .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_id(rsp_id_3),
        .rsp_tag(rsp_tag_3), .rsp_result(rsp_result_3), .rsp_branch(rsp_branch_3),
        .rsp_err(rsp_err_3)
    );

    function automatic alu_op_t mk_op(input logic [5:0] opc, input logic [9:0] xox,
                                      input logic [8:0] xoxo, input logic [15:0] si,
                                      input logic [63:0] rs, input logic [63:0] rt);
        alu_op_t o;
        o = '0;
        o.opcode = opc; o.xox = xox; o.xoxo = xoxo; o.si = si;
        o.rs_val = rs;  o.rt_val = rt;
        return o;
    endfunction

    function automatic exp_t expect_op(input logic id, input alu_op_t o,
                                       input logic [TW-1:0] t, input logic br);
        exp_t e;
        logic ok;
        ok = (o.opcode inside {6'd14, 6'd18, 6'd19, 6'd31, 6'd58, 6'd62}) &&
             !(o.opcode == 6'd31 && o.xox == 10'd0 && o.xoxo == 9'd0);
        e.id     = id;
        e.tag    = t;
        e.err    = !ok;
        e.result = ok ? alu_model(o) : 64'd0;
        e.branch = ok && ((o.opcode == 6'd18) || (o.opcode == 6'd19 && br));
        return e;
    endfunction

    function automatic logic [1:0] model_grant(input logic [1:0] v, input logic p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    // Drive requests at the current negedge, record expectation, step past acceptance
    task automatic issue(input logic [1:0] v, input alu_op_t o0, input logic [TW-1:0] t0,
                         input alu_op_t o1, input logic [TW-1:0] t1, input logic hold,
                         output logic [1:0] rdy, output logic [1:0] gexp);
        req0_pld  = {o0, t0};
        req1_pld  = {o1, t1};
        req_valid = v;
        #1;
        rdy  = req_ready;
        gexp = model_grant(v, mptr);
        if (gexp == 2'b01) sbq.push_back(expect_op(1'b0, o0, t0, tb_br));
        if (gexp == 2'b10) sbq.push_back(expect_op(1'b1, o1, t1, tb_br));
        if (gexp != 2'b00) mptr = ~gexp[1];
        @(negedge clk);
        if (!hold) begin
            req_valid = 2'b00;
            req0_pld  = '1;
            req1_pld  = '1;
        end
    endtask

    // Wait (bounded) for a response, sample it, take it; ends at the IDLE negedge
    task automatic collect(output int lat, output exp_t got);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (rsp_valid !== 1'b1) lat = -1;
        got.id = rsp_id; got.tag = rsp_tag; got.result = rsp_result;
        got.branch = rsp_branch; got.err = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rsp_ready = 1'b0; tb_br = 1'b0; mptr = 1'b0;
        req_valid = 2'b11; req0_pld = '1; req1_pld = '1;
        req_valid_3 = 2'b11; req0_pld_3 = '1; req1_pld_3 = '0;
        rsp_ready_3 = 1'b0; alu_result_3 = '0; alu_branch_3 = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b00) begin
            n_bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready);
        end
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_branch, rsp_err} !== '0) begin
            n_bad++; $display("FAIL reset_rsp_ctl: got v%b id%b tag%h br%b err%b want all 0",
                              rsp_valid, rsp_id, rsp_tag, rsp_branch, rsp_err);
        end
        n_cmp++;
        if (rsp_result !== 64'd0) begin
            n_bad++; $display("FAIL reset_rsp_result: got %h want 0", rsp_result);
        end
        n_cmp++;
        if (alu_pld !== '0) begin
            n_bad++; $display("FAIL reset_alu_pld: got %h want 0", alu_pld);
        end
        n_cmp++;
        if (req_ready_3 !== 2'b00 || rsp_valid_3 !== 1'b0) begin
            n_bad++; $display("FAIL reset_dut3: got rdy %b v %b want 00 0", req_ready_3, rsp_valid_3);
        end
        req_valid = 2'b00; req_valid_3 = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_add();
        logic [1:0] rdy, g;
        int lat;
        exp_t got, e;
        tb_br = 1'b0;
        issue(2'b01, mk_op(OP_XO_X, 10'd0, 9'd266, 16'd0, 64'd8, 64'd7), 4'd3,
              mk_op(6'd7, 10'd0, 9'd0, 16'd0, 64'd1, 64'd1), 4'd0, 1'b0, rdy, g);
        n_cmp++;
        if (rdy !== 2'b01) begin
            n_bad++; $display("FAIL add_ready: got %b want 01", rdy);
        end
        collect(lat, got);
        n_cmp++;
        if (lat + 1 !== 1 + E1) begin
            n_bad++; $display("FAIL add_latency: got %0d want %0d", lat + 1, 1 + E1);
        end
        n_cmp++;
        if (got.result !== 64'd15 || got.id !== 1'b0 || got.tag !== 4'd3 || got.err !== 1'b0) begin
            n_bad++; $display("FAIL add_rsp: got res %0d id %b tag %0d err %b want 15 0 3 0",
                              got.result, got.id, got.tag, got.err);
        end
        if (sbq.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL add_sb: got empty queue want 1 entry");
        end else begin
            e = sbq.pop_front();
            n_cmp++;
            if (got.branch !== e.branch || got.result !== e.result) begin
                n_bad++; $display("FAIL add_sb: got br %b res %h want br %b res %h",
                                  got.branch, got.result, e.branch, e.result);
            end
        end
    endtask

    task automatic test_single_r1();
        logic [1:0] rdy, g;
        int lat;
        exp_t got, e;
        tb_br = 1'b0;
        issue(2'b10, mk_op(6'd7, 10'd0, 9'd0, 16'd0, 64'd0, 64'd0), 4'd0,
              mk_op(OP_XO_X, 10'd0, 9'd266, 16'd0, 64'd100, 64'd23), 4'hA, 1'b0, rdy, g);
        n_cmp++;
        if (rdy !== 2'b10) begin
            n_bad++; $display("FAIL r1_ready: got %b want 10", rdy);
        end
        collect(lat, got);
        if (sbq.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL r1_sb: got empty queue want 1 entry");
        end else begin
            e = sbq.pop_front();
            n_cmp++;
            if (lat < 0 || got.id !== e.id || got.tag !== e.tag || got.result !== e.result ||
                got.err !== e.err || got.id !== 1'b1 || got.result !== 64'd123) begin
                n_bad++; $display("FAIL r1_rsp: got lat %0d id %b tag %h res %0d want id 1 tag a res 123",
                                  lat, got.id, got.tag, got.result);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] rdy, g;
        int lat;
        exp_t got, e;
        time t_prev;
        t_prev = 0;
        tb_br = 1'b0;
        for (int i = 0; i < 8; i++) begin
            issue(2'b11, mk_op(OP_XO_X, 10'd0, 9'd266, 16'd0, 64'(i), 64'd100), 4'(i),
                  mk_op(OP_XO_X, 10'd0, 9'd266, 16'd0, 64'(i), 64'd200), 4'(8 + i), 1'b1, rdy, g);
            n_cmp++;
            if (rdy !== g || rdy !== (i[0] ? 2'b10 : 2'b01)) begin
                n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", i, rdy, g);
            end
            if (i > 0) begin
                n_cmp++;
                if ($time - t_prev !== 64'(10 * (2 + E1))) begin
                    n_bad++; $display("FAIL rr_spacing[%0d]: got %0t want %0d", i, $time - t_prev, 10 * (2 + E1));
                end
            end
            t_prev = $time;
            collect(lat, got);
            if (sbq.size() == 0) begin
                n_cmp++; n_bad++; $display("FAIL rr_sb[%0d]: got empty queue want entry", i);
            end else begin
                e = sbq.pop_front();
                n_cmp++;
                if (lat < 0 || got.id !== e.id || got.id !== i[0] || got.tag !== e.tag ||
                    got.result !== e.result || got.err !== e.err) begin
                    n_bad++; $display("FAIL rr_rsp[%0d]: got id %b tag %h res %0d want id %b tag %h res %0d",
                                      i, got.id, got.tag, got.result, e.id, e.tag, e.result);
                end
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        logic [1:0] rdy, g, gnext;
        exp_t snap, e;
        logic stable;
        tb_br = 1'b1;
        @(negedge clk);
        issue(2'b01, mk_op(OP_DS_LD, 10'd0, 9'd0, 16'd0, 64'hFF00, 64'h00FF), 4'd6,
              mk_op(6'd7, 10'd0, 9'd0, 16'd0, 64'd0, 64'd0), 4'd0, 1'b0, rdy, g);
        req_valid = 2'b11;
        #1;
        n_cmp++;
        if (rdy !== 2'b01 || req_ready !== 2'b00) begin
            n_bad++; $display("FAIL bp_exec_ready: got accept %b exec %b want 01 00", rdy, req_ready);
        end
        @(negedge clk);
        snap.id = rsp_id; snap.tag = rsp_tag; snap.result = rsp_result;
        snap.branch = rsp_branch; snap.err = rsp_err;
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (rsp_valid !== 1'b1 || req_ready !== 2'b00 || rsp_id !== snap.id ||
                rsp_tag !== snap.tag || rsp_result !== snap.result ||
                rsp_branch !== snap.branch || rsp_err !== snap.err)
                stable = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (stable !== 1'b1 || rsp_valid !== 1'b1) begin
            n_bad++; $display("FAIL bp_hold: got stable %b valid %b want 1 1", stable, rsp_valid);
        end
        if (sbq.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL bp_sb: got empty queue want entry");
        end else begin
            e = sbq.pop_front();
            n_cmp++;
            if (snap.result !== e.result || snap.tag !== e.tag || snap.branch !== e.branch ||
                snap.err !== e.err || snap.id !== e.id) begin
                n_bad++; $display("FAIL bp_rsp: got res %h tag %h br %b want res %h tag %h br %b",
                                  snap.result, snap.tag, snap.branch, e.result, e.tag, e.branch);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        gnext = model_grant(2'b11, mptr);
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== gnext) begin
            n_bad++; $display("FAIL bp_idle: got v %b rdy %b want 0 %b", rsp_valid, req_ready, gnext);
        end
        req_valid = 2'b00;  // withdrawn before any edge: no grant, pointer kept
    endtask

    task automatic test_err_branch();
        alu_op_t ops [8];
        logic    brs [8];
        logic [1:0] v, rdy, g;
        int lat;
        exp_t got, e;
        ops[0] = mk_op(6'd7,     10'd0, 9'd266, 16'd0,     64'd5,    64'd6);   brs[0] = 1'b1;
        ops[1] = mk_op(OP_XO_X,  10'd0, 9'd0,   16'd0,     64'd5,    64'd6);   brs[1] = 1'b0;
        ops[2] = mk_op(OP_I,     10'd0, 9'd0,   16'h0040,  64'd1,    64'd2);   brs[2] = 1'b0;
        ops[3] = mk_op(OP_B,     10'd0, 9'd0,   16'h0010,  64'd3,    64'd4);   brs[3] = 1'b1;
        ops[4] = mk_op(OP_B,     10'd0, 9'd0,   16'h0010,  64'd3,    64'd4);   brs[4] = 1'b0;
        ops[5] = mk_op(OP_DS_ST, 10'd0, 9'd0,   16'd0,     64'hF0,   64'h0F);  brs[5] = 1'b1;
        ops[6] = mk_op(OP_D,     10'd0, 9'd0,   16'hFFFE,  64'd0,    64'd7);   brs[6] = 1'b1;
        ops[7] = mk_op(OP_XO_X,  10'd1, 9'd0,   16'd0,     64'd40,   64'd2);   brs[7] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            tb_br = brs[i];
            v = i[0] ? 2'b10 : 2'b01;
            issue(v, ops[i], 4'(i + 1), ops[i], 4'(i + 1), 1'b0, rdy, g);
            n_cmp++;
            if (rdy !== v) begin
                n_bad++; $display("FAIL eb_ready[%0d]: got %b want %b", i, rdy, v);
            end
            collect(lat, got);
            if (sbq.size() == 0) begin
                n_cmp++; n_bad++; $display("FAIL eb_sb[%0d]: got empty queue want entry", i);
            end else begin
                e = sbq.pop_front();
                n_cmp++;
                if (lat < 0 || got.err !== e.err || got.result !== e.result ||
                    got.branch !== e.branch || got.tag !== e.tag || got.id !== e.id) begin
                    n_bad++; $display("FAIL eb_rsp[%0d]: got err %b res %h br %b want err %b res %h br %b",
                                      i, got.err, got.result, got.branch, e.err, e.result, e.branch);
                end
            end
            if (i == 0) begin
                n_cmp++;
                if (got.err !== 1'b1 || got.result !== 64'd0) begin
                    n_bad++; $display("FAIL eb_op7: got err %b res %h want 1 0", got.err, got.result);
                end
            end
            if (i == 2) begin
                n_cmp++;
                if (got.branch !== 1'b1) begin
                    n_bad++; $display("FAIL eb_op18: got br %b want 1", got.branch);
                end
            end
        end
        tb_br = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        logic [1:0] rdy, g;
        int lat, seen;
        exp_t got, e;
        exp_t dropped;
        tb_br = 1'b0;
        issue(2'b01, mk_op(OP_XO_X, 10'd0, 9'd266, 16'd0, 64'd50, 64'd60), 4'd9,
              mk_op(6'd7, 10'd0, 9'd0, 16'd0, 64'd0, 64'd0), 4'd0, 1'b0, rdy, g);
        if (sbq.size() > 0) dropped = sbq.pop_back();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_branch, rsp_err, req_ready} !== '0 ||
            rsp_result !== 64'd0 || alu_pld !== '0) begin
            n_bad++; $display("FAIL rst_async: got v%b tag%h res%h pld_nz%b want all 0",
                              rsp_valid, rsp_tag, rsp_result, alu_pld != '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mptr  = 1'b0;
        seen  = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++; $display("FAIL rst_no_rsp: got %0d valid cycles want 0", seen);
        end
        issue(2'b11, mk_op(OP_XO_X, 10'd0, 9'd266, 16'd0, 64'd1, 64'd2), 4'd4,
              mk_op(OP_XO_X, 10'd0, 9'd266, 16'd0, 64'd3, 64'd4), 4'd5, 1'b0, rdy, g);
        n_cmp++;
        if (rdy !== 2'b01) begin
            n_bad++; $display("FAIL rst_regrant: got %b want 01", rdy);
        end
        collect(lat, got);
        if (sbq.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL rst_sb: got empty queue want entry");
        end else begin
            e = sbq.pop_front();
            n_cmp++;
            if (lat < 0 || got.id !== e.id || got.tag !== e.tag || got.result !== e.result) begin
                n_bad++; $display("FAIL rst_rsp: got id %b tag %h res %0d want id %b tag %h res %0d",
                                  got.id, got.tag, got.result, e.id, e.tag, e.result);
            end
        end
    endtask

    task automatic test_exec3();
        alu_op_t o;
        logic ok_hold;
        o = mk_op(OP_D, 10'd0, 9'd0, 16'd2, 64'd0, 64'd7);
        @(negedge clk);
        req0_pld_3 = {o, 4'd5}; req_valid_3 = 2'b01; alu_result_3 = 64'hBAD;
        #1;
        n_cmp++;
        if (req_ready_3 !== 2'b01) begin
            n_bad++; $display("FAIL x3_ready: got %b want 01", req_ready_3);
        end
        @(negedge clk);
        req_valid_3 = 2'b00; req0_pld_3 = '1;
        ok_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (alu_pld_3 !== ALU_OP_W'(o) || rsp_valid_3 !== 1'b0) ok_hold = 1'b0;
            alu_result_3 = (c == 2) ? 64'd9 : 64'hBAD0 + 64'(c);
            @(negedge clk);
        end
        n_cmp++;
        if (ok_hold !== 1'b1) begin
            n_bad++; $display("FAIL x3_pld_hold: got hold %b want 1", ok_hold);
        end
        alu_result_3 = 64'hBAD;
        #1;
        n_cmp++;
        if (rsp_valid_3 !== 1'b1 || rsp_result_3 !== 64'd9 || rsp_tag_3 !== 4'd5 ||
            rsp_id_3 !== 1'b0 || rsp_err_3 !== 1'b0 || rsp_branch_3 !== 1'b0) begin
            n_bad++; $display("FAIL x3_rsp: got v %b res %h tag %h err %b want 1 9 5 0",
                              rsp_valid_3, rsp_result_3, rsp_tag_3, rsp_err_3);
        end
        rsp_ready_3 = 1'b1;
        @(negedge clk);
        rsp_ready_3 = 1'b0;
        n_cmp++;
        if (rsp_valid_3 !== 1'b0) begin
            n_bad++; $display("FAIL x3_idle: got v %b want 0", rsp_valid_3);
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_single_r1();
        test_round_robin();
        test_backpressure();
        test_err_branch();
        test_reset_mid_exec();
        test_exec3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 want earlier finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_issue_arb.md
ALU_ISSUE_ARB -- requirements
Module: alu_issue_arb

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, meaning ALU settle cycles per operation (legal 1..15).
REQ-002 SHALL have parameter TAG_W, default 4, meaning requester tag width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 2, per-requester operation valid (bit0 = requester 0).
REQ-006 SHALL have port req_ready, output, 2, per-requester accept; one-hot or zero.
REQ-007 SHALL have ports req0_pld and req1_pld, input, 184+TAG_W each, alu_req_t payload: opcode[6], xox[10], xoxo[9], aa[1], si[16], ds[14], rs_val[64], rt_val[64], tag[TAG_W].
REQ-008 SHALL have port alu_pld, output, 184, latched operation fields (payload minus tag) driving the shared ALU.
REQ-009 SHALL have ports alu_result (input, 64) and alu_branch (input, 1), the shared ALU outputs.
REQ-010 SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1), the response handshake.
REQ-011 SHALL have ports rsp_id (output, 1), rsp_tag (output, TAG_W), rsp_result (output, 64), rsp_branch (output, 1) and rsp_err (output, 1), the response payload.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-013 IDLE: with any req_valid set, SHALL assert req_ready for the granted requester in the same cycle (combinational), latch its payload and move to EXEC.
REQ-014 Grant SHALL be round-robin: if both are valid, the requester not granted last wins; after reset, requester 0 has priority.
REQ-015 The priority pointer SHALL update only on a grant; a single valid requester SHALL always win.
REQ-016 req_ready SHALL be 0 in EXEC and RESP; a requester's payload is consumed only when its valid and ready are both high.
REQ-017 EXEC SHALL hold alu_pld stable for exactly EXEC_CYCLES cycles (counter), capture alu_result/alu_branch on the last EXEC cycle, then move to RESP.
REQ-018 RESP SHALL hold rsp_valid=1 with a stable payload until rsp_ready=1; on that cycle it SHALL return to IDLE.
REQ-019 There SHALL be no IDLE bypass: minimum 2+EXEC_CYCLES cycles from acceptance to the next acceptance.
REQ-020 rsp_err SHALL be 1 (rsp_result 0, rsp_branch 0) when opcode is not in {14,18,19,31,58,62}, or when opcode 31 has xox=0 and xoxo=0.
REQ-021 For opcode 18, rsp_branch SHALL be 1 regardless of alu_branch; for any opcode other than 18 and 19, rsp_branch SHALL be 0.
REQ-022 rsp_id SHALL identify the granted requester; rsp_tag SHALL equal the latched tag unmodified.
REQ-023 A deasserted req_valid before grant SHALL be no-op; withdrawal after acceptance SHALL not affect the operation in flight.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE, the counter to 0, the pointer to requester 0, and outputs req_ready=0, rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_result=0, rsp_branch=0, rsp_err=0, alu_pld=0.
REQ-025 Reset mid-EXEC or mid-RESP SHALL discard the operation with no response produced; operation resumes on the first clock edge after rst_n rises.

Structure
REQ-026 A shared package SHALL hold alu_req_t, the FSM state enum, and the opcode constants (OP_XO_X=31, OP_B=19, OP_I=18, OP_D=14, OP_DS_LD=58, OP_DS_ST=62).
REQ-027 The round-robin grant SHALL be a sub-module rr_arb2 (inputs valid[2], update, pointer state; output one-hot grant).
REQ-028 The ALU itself SHALL stay external; this block only sequences and shares it.

Verification
REQ-029 Requester 0 alone, ADD (op31, xoxo 266), rs_val 8, rt_val 7, tag 3 -> req_ready=01 in the first cycle, rsp_valid after 1+EXEC_CYCLES cycles, result 15, id 0, tag 3, err 0.
REQ-030 Both valid continuously, four operations each -> grant order 0,1,0,1,... ; responses alternate rsp_id 0,1.
REQ-031 rsp_ready held low 5 cycles in RESP -> rsp_valid and payload stable, req_ready=00 throughout, then return to IDLE the cycle after rsp_ready=1.
REQ-032 Opcode 7 -> rsp_err=1, rsp_result=0; opcode 18 -> rsp_branch=1 with alu_branch=0.
REQ-033 rst_n pulsed low during EXEC -> outputs zero asynchronously, no response; next grant goes to requester 0.
REQ-034 EXEC_CYCLES=3, ADDI rt_val 7, si 2 -> alu_pld stable for 3 cycles, result 9 captured on the third cycle.
